// File: rtl/ip_sdram_arbiter.sv
// N-port request arbiter and auto-refresh scheduler driving the ip_sdram command strobes.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN: lowest-numbered requester wins instead of round-robin.
module ip_sdram_arbiter #(
   parameter int unsigned NUM_PORTS     = 2,
   parameter int unsigned ADDR_W        = 23,
   parameter int unsigned WDATA_W       = 8,
   parameter int unsigned RDATA_W       = 32,
   parameter int unsigned RFSH_INTERVAL = 832,
   parameter int unsigned RD_TIMEOUT    = 64
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_PORTS-1:0]         p_req,
   input  logic [NUM_PORTS-1:0]         p_wr,
   input  logic [NUM_PORTS*ADDR_W-1:0]  p_address,
   input  logic [NUM_PORTS*WDATA_W-1:0] p_wdata,
   output logic [NUM_PORTS-1:0]         p_ack,
   output logic [RDATA_W-1:0]           p_rdata,
   output logic [NUM_PORTS-1:0]         p_rdata_en,
   input  logic                         sdram_init_busy,
   input  logic                         sdram_busy,
   output logic                         mreq_n,
   output logic                         wr_n,
   output logic                         rd_n,
   output logic                         rfsh_n,
   output logic [ADDR_W-1:0]            address,
   output logic [WDATA_W-1:0]           wdata,
   input  logic [RDATA_W-1:0]           rdata,
   input  logic                         rdata_en,
   output logic                         rd_timeout
);

   localparam int unsigned IdxW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned RfshW = $clog2(RFSH_INTERVAL + 1);
   localparam int unsigned ToW   = $clog2(RD_TIMEOUT + 1);
   localparam logic [RfshW-1:0] RfshReload = RfshW'(RFSH_INTERVAL - 1);
   localparam logic [ToW-1:0]   ToLast     = ToW'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {StInit, StIdle, StIssue, StRfsh, StDone, StWaitRd} state_e;

   state_e               state_q, state_d;
   logic [RfshW-1:0]     rfsh_cnt_q, rfsh_cnt_d;
   logic                 rfsh_pend_q, rfsh_pend_d;
   logic [ToW-1:0]       to_cnt_q, to_cnt_d;
   logic [IdxW-1:0]      last_grant_q, last_grant_d;
   logic [IdxW-1:0]      grant_q, grant_d;
   logic                 cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [WDATA_W-1:0]   wdata_q, wdata_d;
   logic [NUM_PORTS-1:0] p_ack_q, p_ack_d;
   logic [RDATA_W-1:0]   p_rdata_q, p_rdata_d;
   logic [NUM_PORTS-1:0] p_rdata_en_q, p_rdata_en_d;
   logic                 rd_timeout_q, rd_timeout_d;

   logic                 sel_valid;
   logic [IdxW-1:0]      sel_idx;
   logic                 sel_wr;
   logic [ADDR_W-1:0]    sel_addr;
   logic [WDATA_W-1:0]   sel_wdata;
   logic                 accept;
   logic                 grant_now;
   logic [NUM_PORTS-1:0] grant_oh;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (p_req[i]) begin
            sel_valid = 1'b1;
            sel_idx   = IdxW'(i);
         end
      end
   end
`else
   // Scan offsets farthest-first so the requester nearest after last_grant is assigned last.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (p_req[i] && ((int'(last_grant_q) + k) % int'(NUM_PORTS)) == i) begin
               sel_valid = 1'b1;
               sel_idx   = IdxW'(i);
            end
         end
      end
   end
`endif

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      grant_oh  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sel_idx == IdxW'(i)) begin
            sel_wr    = p_wr[i];
            sel_addr  = p_address[i*ADDR_W +: ADDR_W];
            sel_wdata = p_wdata[i*WDATA_W +: WDATA_W];
         end
         grant_oh[i] = (grant_q == IdxW'(i));
      end
   end

   assign accept    = ((state_q == StIssue) || (state_q == StRfsh)) && !sdram_busy;
   assign grant_now = (state_q == StIdle) && !rfsh_pend_q && sel_valid;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit:   if (!sdram_init_busy) state_d = StIdle;
         StIdle: begin
            if (rfsh_pend_q)    state_d = StRfsh;
            else if (sel_valid) state_d = StIssue;
         end
         StIssue:  if (!sdram_busy) state_d = cmd_wr_q ? StDone : StWaitRd;
         StRfsh:   if (!sdram_busy) state_d = StIdle;
         StDone:   state_d = StIdle;
         StWaitRd: if (rdata_en || (to_cnt_q == ToLast)) state_d = StIdle;
         default:  state_d = StInit;
      endcase
   end

   // Outputs: strobes decode straight from state so reset releases them asynchronously.
   always_comb begin
      mreq_n     = !((state_q == StIssue) || (state_q == StRfsh));
      wr_n       = !((state_q == StIssue) && cmd_wr_q);
      rd_n       = !((state_q == StIssue) && !cmd_wr_q);
      rfsh_n     = !(state_q == StRfsh);
      address    = addr_q;
      wdata      = wdata_q;
      p_ack      = p_ack_q;
      p_rdata    = p_rdata_q;
      p_rdata_en = p_rdata_en_q;
      rd_timeout = rd_timeout_q;
   end

   always_comb begin
      rfsh_cnt_d   = rfsh_cnt_q;
      rfsh_pend_d  = rfsh_pend_q;
      to_cnt_d     = '0;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cmd_wr_d     = cmd_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      p_ack_d      = '0;
      p_rdata_d    = p_rdata_q;
      p_rdata_en_d = '0;
      rd_timeout_d = rd_timeout_q;

      if (state_q == StInit) begin
         rfsh_cnt_d = RfshReload;
      end else if (rfsh_cnt_q == '0) begin
         rfsh_cnt_d = RfshReload;
      end else begin
         rfsh_cnt_d = rfsh_cnt_q - 1'b1;
      end
      // A new tick landing on the refresh-accept edge survives; otherwise depth is capped at 1.
      if (accept && (state_q == StRfsh)) rfsh_pend_d = 1'b0;
      if ((state_q != StInit) && (rfsh_cnt_q == '0)) rfsh_pend_d = 1'b1;

      if (grant_now) begin
         grant_d  = sel_idx;
         cmd_wr_d = sel_wr;
         addr_d   = sel_addr;
         wdata_d  = sel_wdata;
      end

      if (accept && (state_q == StIssue)) begin
         p_ack_d      = grant_oh;
         last_grant_d = grant_q;
      end

      if (state_q == StWaitRd) begin
         to_cnt_d = to_cnt_q + 1'b1;
         if (rdata_en) begin
            p_rdata_d    = rdata;
            p_rdata_en_d = grant_oh;
         end else if (to_cnt_q == ToLast) begin
            rd_timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rfsh_cnt_q   <= RfshReload;
         rfsh_pend_q  <= 1'b0;
         to_cnt_q     <= '0;
         last_grant_q <= '0;
         grant_q      <= '0;
         cmd_wr_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         p_ack_q      <= '0;
         p_rdata_q    <= '0;
         p_rdata_en_q <= '0;
         rd_timeout_q <= 1'b0;
      end else begin
         rfsh_cnt_q   <= rfsh_cnt_d;
         rfsh_pend_q  <= rfsh_pend_d;
         to_cnt_q     <= to_cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cmd_wr_q     <= cmd_wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         p_ack_q      <= p_ack_d;
         p_rdata_q    <= p_rdata_d;
         p_rdata_en_q <= p_rdata_en_d;
         rd_timeout_q <= rd_timeout_d;
      end
   end

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Self-checking bench for ip_sdram_arbiter: controller model, per-port command scoreboards and
// read-data scoreboard, one task per scenario.
module tb_ip_sdram_arbiter;

   logic        clk;
   logic        reset_n;
   logic        req0, req1, wr0, wr1;
   logic [22:0] addr0, addr1;
   logic [7:0]  wd0, wd1;
   logic [1:0]  p_req, p_wr, p_ack, p_rdata_en;
   logic [45:0] p_address;
   logic [15:0] p_wdata;
   logic [31:0] p_rdata;
   logic        sdram_init_busy, sdram_busy;
   logic        mreq_n, wr_n, rd_n, rfsh_n;
   logic [22:0] address;
   logic [7:0]  wdata;
   logic [31:0] rdata;
   logic        rdata_en;
   logic        rd_timeout;

   assign p_req     = {req1, req0};
   assign p_wr      = {wr1, wr0};
   assign p_address = {addr1, addr0};
   assign p_wdata   = {wd1, wd0};

   ip_sdram_arbiter #(
      .NUM_PORTS(2), .ADDR_W(23), .WDATA_W(8), .RDATA_W(32),
      .RFSH_INTERVAL(64), .RD_TIMEOUT(64)
   ) dut (
      .clk(clk), .reset_n(reset_n), .p_req(p_req), .p_wr(p_wr), .p_address(p_address),
      .p_wdata(p_wdata), .p_ack(p_ack), .p_rdata(p_rdata), .p_rdata_en(p_rdata_en),
      .sdram_init_busy(sdram_init_busy), .sdram_busy(sdram_busy), .mreq_n(mreq_n),
      .wr_n(wr_n), .rd_n(rd_n), .rfsh_n(rfsh_n), .address(address), .wdata(wdata),
      .rdata(rdata), .rdata_en(rdata_en), .rd_timeout(rd_timeout)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Controller model state
   int          busy_cfg = 0;
   int          busy_left = 0;
   bit          cmd_active = 0;
   bit          rd_resp_en = 1;
   bit          late_inject = 0;
   int          rd_pipe = 0;
   logic [31:0] rd_word;
   logic [7:0]  mem [0:255];
   logic [31:0] last_cmd = '0;
   int          rfsh_log[$];
   int          ack_log[$];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [33:0] exp_rd[$];
   int          ack_overlap = 0;
   int          strobe_clash = 0;
   logic [31:0] mon_e;
   logic [33:0] mon_r;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor first (sees what the DUT saw at the last edge), then advance the controller model.
   always @(negedge clk) begin
      if (p_ack != 2'b00) begin
         if ($countones(p_ack) != 1) ack_overlap++;
         if (p_ack[0]) begin
            ack_log.push_back(0);
            checks++;
            if (exp_q0.size() == 0) begin
               errors++;
               $display("FAIL ack_unexpected port=0 cmd=%h", last_cmd);
            end else begin
               mon_e = exp_q0.pop_front();
               if (last_cmd !== mon_e) begin
                  errors++;
                  $display("FAIL ack_cmd port=0 got=%h required=%h", last_cmd, mon_e);
               end
            end
         end
         if (p_ack[1]) begin
            ack_log.push_back(1);
            checks++;
            if (exp_q1.size() == 0) begin
               errors++;
               $display("FAIL ack_unexpected port=1 cmd=%h", last_cmd);
            end else begin
               mon_e = exp_q1.pop_front();
               if (last_cmd !== mon_e) begin
                  errors++;
                  $display("FAIL ack_cmd port=1 got=%h required=%h", last_cmd, mon_e);
               end
            end
         end
      end
      if (p_rdata_en != 2'b00) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rdata_unexpected en=%b data=%h", p_rdata_en, p_rdata);
         end else begin
            mon_r = exp_rd.pop_front();
            if ({p_rdata_en, p_rdata} !== mon_r || rdata_en !== 1'b1) begin
               errors++;
               $display("FAIL rdata got en=%b data=%h src_en=%b required en=%b data=%h src_en=1",
                        p_rdata_en, p_rdata, rdata_en, mon_r[33:32], mon_r[31:0]);
            end
         end
      end

      rdata_en = 1'b0;
      if (late_inject) begin
         rdata    = 32'hDEADBEEF;
         rdata_en = 1'b1;
         late_inject = 0;
      end
      if (rd_pipe != 0) begin
         rd_pipe--;
         if (rd_pipe == 0) begin
            rdata    = rd_word;
            rdata_en = 1'b1;
         end
      end
      if (!rfsh_n && (!wr_n || !rd_n)) strobe_clash++;
      if (!mreq_n) begin
         if (!cmd_active) begin
            cmd_active = 1;
            busy_left  = busy_cfg;
         end
         if (busy_left != 0) begin
            sdram_busy = 1'b1;
            busy_left--;
         end else begin
            sdram_busy = 1'b0;
            cmd_active = 0;
            if (!rfsh_n) begin
               rfsh_log.push_back(cyc);
            end else begin
               last_cmd = {!wr_n, address, wdata};
               if (!wr_n) begin
                  mem[address[7:0]] = wdata;
               end else if (rd_resp_en) begin
                  rd_word = {mem[{address[7:2], 2'd3}], mem[{address[7:2], 2'd2}],
                             mem[{address[7:2], 2'd1}], mem[{address[7:2], 2'd0}]};
                  rd_pipe = 2;
               end
            end
         end
      end else begin
         sdram_busy = 1'b0;
         cmd_active = 0;
      end
   end

   task automatic set_port(input bit port, input bit req, input bit wr, input logic [22:0] a,
                           input logic [7:0] d);
      if (port) begin
         req1 = req; wr1 = wr; addr1 = a; wd1 = d;
      end else begin
         req0 = req; wr0 = wr; addr0 = a; wd0 = d;
      end
   endtask

   // Issue n back-to-back commands from one port, holding p_req across them.
   task automatic drive_port(input bit port, input int n, input logic [7:0] base, input bit wr,
                             input logic [7:0] d0);
      logic [22:0] a;
      logic [7:0]  d;
      int          t;
      for (int k = 0; k < n; k++) begin
         a = 23'(base) + 23'(k);
         d = d0 + 8'(k) * 8'h11;
         set_port(port, 1'b1, wr, a, d);
         if (port) exp_q1.push_back({wr, a, d});
         else      exp_q0.push_back({wr, a, d});
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!p_ack[port] && t < 300);
         checks++;
         if (!p_ack[port]) begin
            errors++;
            $display("FAIL ack_wait port=%0d got no ack, required ack within 300 cycles", port);
         end
      end
      if (port) req1 = 1'b0;
      else      req0 = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({mreq_n, wr_n, rd_n, rfsh_n} !== 4'b1111) begin
         errors++;
         $display("FAIL reset_strobes got=%b required=1111", {mreq_n, wr_n, rd_n, rfsh_n});
      end
      checks++;
      if (address !== 23'd0 || wdata !== 8'd0) begin
         errors++;
         $display("FAIL reset_addr_data got addr=%h wdata=%h required 0/0", address, wdata);
      end
      checks++;
      if (p_ack !== 2'b00 || p_rdata_en !== 2'b00 || p_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_port_outs got ack=%b en=%b rdata=%h required 0", p_ack, p_rdata_en,
                  p_rdata);
      end
      checks++;
      if (rd_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_rd_timeout got=%b required=0", rd_timeout);
      end
   endtask

   task automatic test_init();
      int bad;
      int t;
      int rel;
      @(negedge clk);
      reset_n = 1'b1;
      set_port(1'b0, 1'b1, 1'b1, 23'h10, 8'hAA);
      exp_q0.push_back({1'b1, 23'h10, 8'hAA});
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!mreq_n) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL init_no_grant got %0d cycles with mreq_n=0, required 0", bad);
      end
      sdram_init_busy = 1'b0;
      rel = cyc;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (mreq_n && t < 10);
      checks++;
      if (mreq_n || t > 2 || !rfsh_n || wr_n) begin
         errors++;
         $display("FAIL init_first_grant got after %0d cycles mreq_n=%b wr_n=%b rfsh_n=%b, required write within 2",
                  t, mreq_n, wr_n, rfsh_n);
      end
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!p_ack[0] && t < 20);
      req0 = 1'b0;
      t = 0;
      while (rfsh_log.size() == 0 && t < 150) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (rfsh_log.size() == 0 || rfsh_log[0] - rel < 64 || rfsh_log[0] - rel > 68) begin
         errors++;
         $display("FAIL init_first_refresh got %0d cycles after release, required 64..68",
                  (rfsh_log.size() == 0) ? -1 : rfsh_log[0] - rel);
      end
   endtask

   task automatic test_busy_write();
      int t;
      int low;
      int good;
      int acks;
      busy_cfg = 3;
      set_port(1'b0, 1'b1, 1'b1, 23'h3, 8'h45);
      exp_q0.push_back({1'b1, 23'h3, 8'h45});
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (wr_n && t < 100);
      req0 = 1'b0;  // dropped after grant: the latched command must still complete
      low  = 0;
      good = 0;
      acks = 0;
      while (!wr_n && low < 20) begin
         low++;
         if (address == 23'h3 && wdata == 8'h45) good++;
         @(negedge clk);
         if (p_ack[0]) acks++;
      end
      busy_cfg = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (p_ack[0]) acks++;
      end
      checks++;
      if (low != 4 || good != 4) begin
         errors++;
         $display("FAIL busy_hold got low=%0d stable=%0d cycles, required 4/4", low, good);
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL busy_ack_count got=%0d required=1", acks);
      end
      checks++;
      if (mem[3] !== 8'h45) begin
         errors++;
         $display("FAIL busy_mem got=%h required=45", mem[3]);
      end
   endtask

   task automatic test_two_ports();
      int bad;
      ack_log.delete();
      ack_overlap = 0;
      fork
         drive_port(1'b0, 8, 8'h20, 1'b1, 8'h10);
         drive_port(1'b1, 8, 8'h40, 1'b1, 8'h90);
      join
      repeat (4) @(negedge clk);
      bad = 0;
      for (int k = 0; k < ack_log.size(); k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         if (ack_log[k] != ((k < 8) ? 0 : 1)) bad++;
`else
         if (k > 0 && ack_log[k] == ack_log[k-1]) bad++;
`endif
      end
      checks++;
      if (ack_log.size() != 16 || bad != 0) begin
         errors++;
         $display("FAIL two_port_order got %0d acks with %0d order faults, required 16 and 0",
                  ack_log.size(), bad);
      end
      checks++;
      if (ack_overlap != 0) begin
         errors++;
         $display("FAIL two_port_overlap got=%0d required=0", ack_overlap);
      end
   endtask

   task automatic test_refresh();
      int bad;
      int d;
      #1;
      rfsh_log.delete();
      strobe_clash = 0;
      drive_port(1'b1, 80, 8'h80, 1'b1, 8'h01);
      bad = 0;
      for (int k = 1; k < rfsh_log.size(); k++) begin
         d = rfsh_log[k] - rfsh_log[k-1];
         if (d < 60 || d > 68) bad++;
      end
      checks++;
      if (rfsh_log.size() < 3 || bad != 0) begin
         errors++;
         $display("FAIL refresh_period got %0d refreshes with %0d intervals off, required >=3 and 0",
                  rfsh_log.size(), bad);
      end
      checks++;
      if (strobe_clash != 0) begin
         errors++;
         $display("FAIL refresh_clash got=%0d required=0", strobe_clash);
      end
   endtask

   task automatic test_read();
      int t;
      drive_port(1'b0, 4, 8'h04, 1'b1, 8'h56);
      exp_rd.push_back({2'b10, 32'h89786756});
      drive_port(1'b1, 1, 8'h07, 1'b0, 8'h00);
      t = 0;
      while (exp_rd.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (exp_rd.size() != 0) begin
         errors++;
         $display("FAIL read_done got %0d pending, required 0", exp_rd.size());
      end
      checks++;
      if (rd_timeout !== 1'b0) begin
         errors++;
         $display("FAIL read_no_timeout got=%b required=0", rd_timeout);
      end
   endtask

   task automatic test_timeout();
      int t;
      int stray;
      rd_resp_en = 0;
      drive_port(1'b0, 1, 8'h04, 1'b0, 8'h00);
      t = 0;
      while (!rd_timeout && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!rd_timeout || t < 63 || t > 65) begin
         errors++;
         $display("FAIL timeout_delay got flag=%b after %0d cycles, required 1 after 64",
                  rd_timeout, t);
      end
      late_inject = 1;
      stray = 0;
      repeat (5) begin
         @(negedge clk);
         if (p_rdata_en != 2'b00) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL timeout_late_data got=%0d pulses required=0", stray);
      end
      rd_resp_en = 1;
      drive_port(1'b0, 1, 8'h30, 1'b1, 8'h5A);
      repeat (2) @(negedge clk);
      checks++;
      if (mem[8'h30] !== 8'h5A || rd_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_recover got mem=%h flag=%b required 5a/1", mem[8'h30], rd_timeout);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      busy_cfg = 10;
      set_port(1'b0, 1'b1, 1'b0, 23'h8, 8'h00);
      exp_q0.push_back({1'b0, 23'h8, 8'h00});
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (mreq_n && t < 100);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({mreq_n, wr_n, rd_n, rfsh_n} !== 4'b1111 || t >= 100) begin
         errors++;
         $display("FAIL midreset_strobes got=%b required=1111", {mreq_n, wr_n, rd_n, rfsh_n});
      end
      checks++;
      if (rd_timeout !== 1'b0 || p_ack !== 2'b00) begin
         errors++;
         $display("FAIL midreset_flags got timeout=%b ack=%b required 0/00", rd_timeout, p_ack);
      end
      req0 = 1'b0;
      exp_q0.delete();
      busy_cfg = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      drive_port(1'b0, 1, 8'h31, 1'b1, 8'h77);
      repeat (6) @(negedge clk);
      checks++;
      if (mem[8'h31] !== 8'h77 || exp_rd.size() != 0) begin
         errors++;
         $display("FAIL midreset_recover got mem=%h pending_rd=%0d required 77/0", mem[8'h31],
                  exp_rd.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset_n         = 1'b0;
      sdram_init_busy = 1'b1;
      sdram_busy      = 1'b0;
      rdata           = '0;
      rdata_en        = 1'b0;
      set_port(1'b0, 1'b0, 1'b0, 23'd0, 8'd0);
      set_port(1'b1, 1'b0, 1'b0, 23'd0, 8'd0);
      test_reset();
      test_init();
      test_busy_write();
      test_two_ports();
      test_refresh();
      test_read();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no completion, required finish within 100000 cycles");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ip_sdram_arbiter.md
Name: ip_sdram_arbiter

Overview:
Parametrised N-port front end for the ip_sdram controller. It arbitrates byte-write and word-read requests from NUM_PORTS clients and drives the controller's mreq_n/wr_n/rd_n/rfsh_n command interface. It schedules auto-refresh itself and routes returned read data back to the port that issued the read. The block sits between the video/CPU clients and ip_sdram, in the same clock domain.

Parameters:
NUM_PORTS, 2, number of client ports (1..8)
ADDR_W, 23, address width, matches ip_sdram
WDATA_W, 8, write data width
RDATA_W, 32, read data width
RFSH_INTERVAL, 832, clock cycles between refresh requests (7.7 us at 108 MHz)
RD_TIMEOUT, 64, maximum cycles to wait for rdata_en after a read is accepted

Ports:
clk  in  1  system clock, also the controller clock
reset_n  in  1  asynchronous active-low reset
p_req  in  NUM_PORTS  per-port request, held high until p_ack
p_wr  in  NUM_PORTS  per-port 1=write, 0=read
p_address  in  NUM_PORTS*ADDR_W  per-port address; port i occupies slice [i*ADDR_W +: ADDR_W]
p_wdata  in  NUM_PORTS*WDATA_W  per-port write data
p_ack  out  NUM_PORTS  one-cycle pulse when the port's command is accepted by the controller
p_rdata  out  RDATA_W  read data, shared by all ports
p_rdata_en  out  NUM_PORTS  one-cycle pulse marking p_rdata valid for port i
sdram_init_busy  in  1  controller initialisation in progress
sdram_busy  in  1  controller cannot accept a command
mreq_n, wr_n, rd_n, rfsh_n  out  1 each  controller command strobes, active low
address  out  ADDR_W  controller address
wdata  out  WDATA_W  controller write data
rdata  in  RDATA_W  controller read data
rdata_en  in  1  controller read data valid
rd_timeout  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (async, reset_n=0) puts the block in INIT. Outputs: all command strobes 1, address=0, wdata=0, p_ack=0, p_rdata=0, p_rdata_en=0, rd_timeout=0. The refresh counter loads RFSH_INTERVAL-1 and the RR pointer is 0.
- INIT: stays while sdram_init_busy=1. No grants. Refresh counter is held at its reload value. Goes to IDLE on the first edge where sdram_init_busy=0.
- Refresh counter runs outside INIT and counts down. At 0 it reloads and sets rfsh_pend. If rfsh_pend is already set at that point, the extra request is dropped; refreshes are never queued deeper than 1.
- IDLE, priority order:
  - rfsh_pend set: go to RFSH with mreq_n=0, rfsh_n=0.
  - else, any p_req: select a port by round-robin, searching from last_grant+1 mod NUM_PORTS. Latch that port's address and wdata onto the controller outputs. Drive mreq_n=0 and either wr_n=0 (p_wr=1) or rd_n=0 (p_wr=0). Go to ISSUE.
- ISSUE/RFSH: a command is accepted on the edge where mreq_n=0 and sdram_busy=0. Strobes are held until that edge and all return to 1 on it.
  - On acceptance in RFSH: clear rfsh_pend, go to IDLE.
  - On acceptance of a write: p_ack[g]=1 for one cycle, go to DONE.
  - On acceptance of a read: p_ack[g]=1 for one cycle, go to WAIT_RD.
  - last_grant is updated on acceptance.
- DONE: one cycle, then IDLE. This gives the client the cycle after p_ack to drop p_req, so the same request is never granted twice.
- WAIT_RD: a timeout counter runs.
  - On rdata_en=1: p_rdata<=rdata and p_rdata_en[g]=1 on the following cycle. Go to IDLE.
  - If RD_TIMEOUT cycles pass without rdata_en: set rd_timeout=1 and go to IDLE. A late rdata_en arriving in IDLE is ignored.
- Latency: p_req sampled at edge E0, mreq_n low from E0, with sdram_busy=0 accepted at E1, p_ack high between E1 and E2. Each extra busy cycle adds one cycle.
- Simultaneous refresh and request in IDLE: refresh wins. The request waits in IDLE and is granted next.
- p_req dropped after grant and before ack: the latched command still completes and is acked.
- Only one command is outstanding at a time; no new grant is made while in WAIT_RD.
- Reset mid-operation: strobes return to 1 immediately (async). Any outstanding read is abandoned without p_rdata_en.

Optional Feature:
SDRAM_ARB_FIXED_PRIO_EN:
- Defined: the lowest-numbered requesting port always wins and the RR pointer is unused. Refresh still has top priority.
- Undefined: round-robin as described above.

Test Plan:
- Hold sdram_init_busy=1 for 200 cycles with p_req[0]=1 -> mreq_n stays 1. After release, first grant within 2 cycles. Refresh counter starts only after release.
- Port0 write 0x000003/0x45 with sdram_busy high 3 cycles -> wr_n=0, address=0x000003, wdata=0x45 held 4 cycles, then p_ack[0] pulses once. Controller model holds 0x45 at byte 3.
- Ports 0 and 1 both request continuously, 8 writes each -> grants alternate 0,1,0,1. p_ack pulses never overlap.
- RFSH_INTERVAL=64, port1 requesting continuously -> rfsh_n=0 issued every 64 cycles ±command length, and never while a port command strobe is low.
- Writes 0x56,0x67,0x78,0x89 to 4..7, then port1 reads 0x000007 -> p_rdata=0x89786756 with p_rdata_en[1]=1 only, one cycle after rdata_en.
- Read with rdata_en never asserted -> rd_timeout=1 after 64 cycles, state back to IDLE, and the next port0 write completes normally. Rerun the two-port test with SDRAM_ARB_FIXED_PRIO_EN defined -> port0 always wins.
